// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset PC, control-flow kinds and the opcode/funct
// encodings that the decoder maps onto those kinds.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    CtrlNone   = 2'd0,
    CtrlBranch = 2'd1,
    CtrlJump   = 2'd2,
    CtrlJreg   = 2'd3
  } ctrl_kind_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational redirect-target calculator for branch, jump and jump-register.
module npc_target_calc
  import mips_pkg::*;
(
  input  ctrl_kind_e  kind_i,
  input  logic [31:0] pc4_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] index26_i,
  input  logic [31:0] rs_i,
  output logic [31:0] target_o
);

  logic [31:0] branch_off;

  // Word offset, sign-extended then scaled to bytes; the add wraps modulo 2^32.
  assign branch_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};

  always_comb begin
    target_o = pc4_i;
    unique case (kind_i)
      CtrlBranch: target_o = pc4_i + branch_off;
      CtrlJump:   target_o = {pc4_i[31:28], index26_i, 2'b00};
      CtrlJreg:   target_o = rs_i;
      default:    target_o = pc4_i;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage program counter with stall hold and a one-entry pending-redirect buffer.
// Optional FETCH_ALIGN_CHK_EN adds a sticky align_err_o for misaligned redirect targets.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        id_valid_i,
  input  logic [1:0]  id_kind_i,
  input  logic        id_taken_i,
  input  logic [31:0] id_pc4_i,
  input  logic [15:0] id_imm16_i,
  input  logic [25:0] id_index26_i,
  input  logic [31:0] id_rs_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        redirect_o,
`ifdef FETCH_ALIGN_CHK_EN
  output logic        align_err_o,
`endif
  output logic        pending_o
);

  import mips_pkg::*;

  typedef enum logic [0:0] {StRun, StPend} state_e;

  ctrl_kind_e  kind;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_q, pend_d, target;
  logic        redirect_q, redirect_d, req;

  assign kind = ctrl_kind_e'(id_kind_i);

  npc_target_calc u_npc_target_calc (
    .kind_i    (kind),
    .pc4_i     (id_pc4_i),
    .imm16_i   (id_imm16_i),
    .index26_i (id_index26_i),
    .rs_i      (id_rs_i),
    .target_o  (target)
  );

  assign req = id_valid_i &
               ((kind == CtrlJump) | (kind == CtrlJreg) | ((kind == CtrlBranch) & id_taken_i));

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    state_d    = state_q;
    redirect_d = 1'b0;
    if (stall_i) begin
      // Newest decision overwrites any older buffered target.
      if (req) begin
        pend_d  = target;
        state_d = StPend;
      end
    end else if (req) begin
      pc_d       = target;
      redirect_d = 1'b1;
      state_d    = StRun;
    end else if (state_q == StPend) begin
      pc_d       = pend_q;
      redirect_d = 1'b1;
      state_d    = StRun;
    end else begin
      pc_d = pc_q + 32'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      state_q    <= StRun;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic align_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      align_err_q <= 1'b0;
    end else if (redirect_d && (pc_d[1:0] != 2'b00)) begin
      align_err_q <= 1'b1;
    end
  end

  assign align_err_o = align_err_q;
`endif

  assign pc_o       = pc_q;
  assign pc4_o      = pc_q + 32'(PC_STEP);
  assign redirect_o = redirect_q;
  assign pending_o  = (state_q == StPend);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed-vector bench for fetch_pc_unit; define FETCH_ALIGN_CHK_EN to cover align_err_o.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, id_valid_i, id_taken_i;
  logic [1:0]  id_kind_i;
  logic [31:0] id_pc4_i, id_rs_i;
  logic [15:0] id_imm16_i;
  logic [25:0] id_index26_i;
  logic [31:0] pc_o, pc4_o;
  logic        redirect_o, pending_o;
`ifdef FETCH_ALIGN_CHK_EN
  logic        align_err_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .id_valid_i   (id_valid_i),
    .id_kind_i    (id_kind_i),
    .id_taken_i   (id_taken_i),
    .id_pc4_i     (id_pc4_i),
    .id_imm16_i   (id_imm16_i),
    .id_index26_i (id_index26_i),
    .id_rs_i      (id_rs_i),
    .pc_o         (pc_o),
    .pc4_o        (pc4_o),
    .redirect_o   (redirect_o),
`ifdef FETCH_ALIGN_CHK_EN
    .align_err_o  (align_err_o),
`endif
    .pending_o    (pending_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid_i = 1'b0;
    id_kind_i  = 2'd0;
    id_taken_i = 1'b0;
  endtask

  task automatic drive(input logic [1:0] kind, input logic taken, input logic [31:0] pc4,
                       input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs);
    id_valid_i   = 1'b1;
    id_kind_i    = kind;
    id_taken_i   = taken;
    id_pc4_i     = pc4;
    id_imm16_i   = imm;
    id_index26_i = idx;
    id_rs_i      = rs;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] pc, input logic redir,
                              input logic pend);
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".redirect"}, {31'b0, redirect_o}, {31'b0, redir});
    check({tag, ".pending"}, {31'b0, pending_o}, {31'b0, pend});
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0;
    id_pc4_i = '0; id_imm16_i = '0; id_index26_i = '0; id_rs_i = '0;
    idle();
    #1;
    step();
    reset = 1'b0;
    expect_state("reset", 32'h3000, 1'b0, 1'b0);
    check("reset.pc4", pc4_o, 32'h3004);
`ifdef FETCH_ALIGN_CHK_EN
    check("reset.align", {31'b0, align_err_o}, 32'd0);
`endif

    // Sequential fetch
    step(); expect_state("seq1", 32'h3004, 1'b0, 1'b0);
    step(); expect_state("seq2", 32'h3008, 1'b0, 1'b0);
    step(); expect_state("seq3", 32'h300C, 1'b0, 1'b0);

    // Taken branch backwards: 0x3008 + (-2 << 2) = 0x3000
    drive(2'd1, 1'b1, 32'h3008, 16'hFFFE, '0, '0);
    step(); expect_state("br_taken", 32'h3000, 1'b1, 1'b0);
    idle();
    step(); expect_state("br_after", 32'h3004, 1'b0, 1'b0);

    // Taken branch under a two-cycle stall: 0x3010 + 16 = 0x3020
    stall_i = 1'b1;
    drive(2'd1, 1'b1, 32'h3010, 16'h0004, '0, '0);
    step(); expect_state("stall1", 32'h3004, 1'b0, 1'b1);
    idle();
    step(); expect_state("stall2", 32'h3004, 1'b0, 1'b1);
    stall_i = 1'b0;
    step(); expect_state("pend_apply", 32'h3020, 1'b1, 1'b0);

    // Untaken branch and NONE kind have no effect
    drive(2'd1, 1'b0, 32'h3024, 16'h0100, '0, '0);
    step(); expect_state("br_untaken", 32'h3024, 1'b0, 1'b0);
    drive(2'd0, 1'b1, 32'h3028, 16'h0100, 26'h1, 32'h9000);
    step(); expect_state("kind_none", 32'h3028, 1'b0, 1'b0);

    // Jump and jump-register
    drive(2'd2, 1'b0, 32'h3000_0010, '0, 26'h0000100, '0);
    step(); expect_state("jump", 32'h3000_0400, 1'b1, 1'b0);
    drive(2'd3, 1'b0, 32'h3000_0404, '0, '0, 32'h0000_4000);
    step(); expect_state("jreg", 32'h0000_4000, 1'b1, 1'b0);
    idle();
    step(); expect_state("jreg_after", 32'h0000_4004, 1'b0, 1'b0);

    // Pending branch superseded by an unstalled jump in the same cycle
    stall_i = 1'b1;
    drive(2'd1, 1'b1, 32'h4008, 16'h0001, '0, '0);
    step(); expect_state("pend5", 32'h4004, 1'b0, 1'b1);
    stall_i = 1'b0;
    drive(2'd2, 1'b0, 32'h4010, '0, 26'h0000080, '0);
    step(); expect_state("jump_wins", 32'h0000_0200, 1'b1, 1'b0);
    idle();
    step(); expect_state("jump_wins_after", 32'h0000_0204, 1'b0, 1'b0);

    // Newest stalled decision overwrites the buffered one
    stall_i = 1'b1;
    drive(2'd3, 1'b0, '0, '0, '0, 32'h5000);
    step(); expect_state("ovw1", 32'h0204, 1'b0, 1'b1);
    drive(2'd3, 1'b0, '0, '0, '0, 32'h6000);
    step(); expect_state("ovw2", 32'h0204, 1'b0, 1'b1);
    stall_i = 1'b0;
    idle();
    step(); expect_state("ovw_apply", 32'h6000, 1'b1, 1'b0);

    // Wraparound at the top of the address space
    drive(2'd3, 1'b0, '0, '0, '0, 32'hFFFF_FFFC);
    step(); expect_state("wrap_load", 32'hFFFF_FFFC, 1'b1, 1'b0);
    check("wrap.pc4", pc4_o, 32'h0);
    idle();
    step(); expect_state("wrap", 32'h0, 1'b0, 1'b0);

    // Reset while a redirect is pending discards it
    stall_i = 1'b1;
    drive(2'd3, 1'b0, '0, '0, '0, 32'h7000);
    step(); expect_state("pend6", 32'h0, 1'b0, 1'b1);
    idle();
    stall_i = 1'b0;
    reset   = 1'b1;
    step(); expect_state("reset_pend", 32'h3000, 1'b0, 1'b0);
    reset = 1'b0;
    step(); expect_state("reset_pend_after", 32'h3004, 1'b0, 1'b0);

    // Misaligned jr target loads as-is
    drive(2'd3, 1'b0, '0, '0, '0, 32'h3002);
    step(); expect_state("misalign", 32'h3002, 1'b1, 1'b0);
`ifdef FETCH_ALIGN_CHK_EN
    check("align.set", {31'b0, align_err_o}, 32'd1);
`endif
    idle();
    step(); expect_state("misalign_after", 32'h3006, 1'b0, 1'b0);
`ifdef FETCH_ALIGN_CHK_EN
    check("align.sticky", {31'b0, align_err_o}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("align.clear", {31'b0, align_err_o}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
